riscv_datapath: RTL

//  Multi-cycle RV32I datapath slaved to the control unit: holds PC, IR, register file, operand/result latches and ALU.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/riscv_regfile.sv | 30 +++
 rtl/riscv_datapath.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared ALU operation codes, opcode constants and word type for the RV32I datapath.
package riscv_pkg;

  typedef logic [31:0] word_t;

  // ALU codes are {funct7[5], funct3}, so the CU can forward instruction bits directly.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired to zero.
// Reads are combinational; a same-edge write is seen by readers only after the edge.
module riscv_regfile
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  word_t      wdata_i,
  input  logic [4:0] raddr1_i,
  input  logic [4:0] raddr2_i,
  output word_t      rdata1_o,
  output word_t      rdata2_o
);

  word_t regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/riscv_datapath.sv
// Multi-cycle RV32I datapath (PC, IR, regfile, A/B/F latches, ALU) driven by CU strobes.
// A/B valid one cycle after IR loads, F/flags one cycle after ALU_OP; no backpressure.
module riscv_datapath
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PC_Write,
  input  logic               IR_Write,
  input  logic               Reg_Write,
  input  logic               rs2_imm_s,
  input  logic               w_data_s,
  input  logic [3:0]         ALU_OP,
  output logic [IMEM_AW-1:0] inst_addr,
  input  logic [31:0]        inst_data,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic               ZF,
  output logic               SF,
  output logic [31:0]        pc_dbg
);

  word_t pc_q, pc_d;
  word_t ir_q, ir_d;
  word_t a_q, b_q, f_q;
  logic  zf_q, sf_q;

  word_t rs1_data, rs2_data;
  word_t imm_i, imm_u;
  word_t op1, op2, alu_res, wb_data;
  logic [4:0] shamt;

  assign pc_d = PC_Write ? (pc_q + 32'd4) : pc_q;
  assign ir_d = IR_Write ? inst_data : ir_q;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {ir_q[31:12], 12'b0};

  assign op1   = a_q;
  assign op2   = rs2_imm_s ? imm_i : b_q;
  assign shamt = op2[4:0];

  always_comb begin
    alu_res = '0;
    case (ALU_OP)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = word_t'($signed(op1) >>> shamt);
      ALU_SLT:  alu_res = {31'b0, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_res = {31'b0, (op1 < op2)};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
      default:  alu_res = '0;
    endcase
  end

  assign wb_data = w_data_s ? imm_u : f_q;

  // Write address comes from the IR held before this edge, so fetch and write-back can overlap.
  riscv_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (Reg_Write),
    .waddr_i  (ir_q[11:7]),
    .wdata_i  (wb_data),
    .raddr1_i (ir_q[19:15]),
    .raddr2_i (ir_q[24:20]),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= rs1_data;
      b_q  <= rs2_data;
      f_q  <= alu_res;
      zf_q <= (alu_res == '0);
      sf_q <= alu_res[31];
    end
  end

  assign inst_addr = pc_q[IMEM_AW+1:2];
  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign ZF        = zf_q;
  assign SF        = sf_q;
  assign pc_dbg    = pc_q;

endmodule
